// File: rtl/wb_store_buffer_if.sv
// wb_store_buffer_if: bundles the WB store path, MEM write port, PRE-stage conflict check
// and drain handshake of the store buffer.
// Ports: master = pipeline/memory side (drives stores, busy, check address, flush request),
//        slave  = store buffer (drives stall, head write request, hit, flush done, occupancy).
interface wb_store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int SIZE_W = 2,
    parameter int PTR_W  = 2
);
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [SIZE_W-1:0] wr_size;
    logic              wr_stall;
    logic              mem_wt_en;
    logic [ADDR_W-1:0] mem_wt_addr;
    logic [DATA_W-1:0] mem_wt_data;
    logic [SIZE_W-1:0] mem_wt_size;
    logic              mem_busy;
    logic [ADDR_W-1:0] chk_addr;
    logic              chk_hit;
    logic              flush_req;
    logic              flush_done;
    logic [PTR_W:0]    count;
    logic              empty;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_size, mem_busy, chk_addr, flush_req,
        input  wr_stall, mem_wt_en, mem_wt_addr, mem_wt_data, mem_wt_size,
               chk_hit, flush_done, count, empty
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_size, mem_busy, chk_addr, flush_req,
        output wr_stall, mem_wt_en, mem_wt_addr, mem_wt_data, mem_wt_size,
               chk_hit, flush_done, count, empty
    );
endinterface

// File: rtl/wb_store_buffer.sv
// wb_store_buffer: in-order write-back store queue between WB and the MEM write port.
// Latency: a pushed store reaches mem_wt_* one cycle later at the earliest; stall is registered-state only.
// Ports: CLK/CLR (async active-high reset), bus = wb_store_buffer_if.slave
//        (WB push + stall, MEM head write + busy, PRE 8-byte-block hit check, flush drain handshake).
module wb_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int SIZE_W = 2
) (
    input  logic CLK,
    input  logic CLR,
    wb_store_buffer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRAIN, DONE, WAIT} state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [SIZE_W-1:0] size_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W:0]    cnt;

    state_t state;
    state_t state_nxt;

    logic full;
    logic is_empty;
    logic stall;
    logic done;
    logic push;
    logic pop;
    logic hit;

    assign full     = (cnt == FULL_CNT);
    assign is_empty = (cnt == '0);
    // stall comes only from registered count/state, so mem_busy never reaches wr_stall;
    // a pop in a full cycle therefore cannot admit a push until the next cycle
    assign push     = bus.wr_valid && !stall;
    assign pop      = !is_empty && !bus.mem_busy;

    // entry storage
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                size_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            // head and tail only coincide when empty (no pop) or full (no push)
            if (pop) begin
                vld_q[head] <= 1'b0;
            end
            if (push) begin
                addr_q[tail] <= bus.wr_addr;
                data_q[tail] <= bus.wr_data;
                size_q[tail] <= bus.wr_size;
                vld_q[tail]  <= 1'b1;
            end
        end
    end

    // pointers and occupancy
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + (PTR_W + 1)'(1);
                2'b01:   cnt <= cnt - (PTR_W + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // drain FSM: state register
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // drain FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.flush_req) state_nxt = DRAIN;
            DRAIN:   if (is_empty)      state_nxt = DONE;
            DONE:                       state_nxt = WAIT;
            WAIT:    if (!bus.flush_req) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // drain FSM: outputs
    always_comb begin
        stall = full || (state != IDLE);
        done  = (state == DONE);
    end

    // block-granular (8-byte) conflict check; the head entry stays valid until its
    // retiring edge, so it still hits in the cycle it is written out
    always_comb begin
        hit = push && (bus.wr_addr[ADDR_W-1:3] == bus.chk_addr[ADDR_W-1:3]);
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (addr_q[i][ADDR_W-1:3] == bus.chk_addr[ADDR_W-1:3])) begin
                hit = 1'b1;
            end
        end
    end

    assign bus.wr_stall    = stall;
    assign bus.mem_wt_en   = !is_empty;
    assign bus.mem_wt_addr = is_empty ? '0 : addr_q[head];
    assign bus.mem_wt_data = is_empty ? '0 : data_q[head];
    assign bus.mem_wt_size = is_empty ? '0 : size_q[head];
    assign bus.chk_hit     = hit;
    assign bus.flush_done  = done;
    assign bus.count       = cnt;
    assign bus.empty       = is_empty;
endmodule

// File: doc/wb_store_buffer.md
Name: wb_store_buffer

Overview:
- Parametrised write-back store queue between the WB stage memory-write path and the MEM stage write port.
- Accepts committed stores from WB and absorbs memory-port busy cycles without stalling EX, up to DEPTH entries.
- Provides an address-conflict check to the PRE stage and a drain handshake used on halt/serialising instructions.

Parameters:
DEPTH, 4, number of store entries; power of two, 2..16
PTR_W, 2, log2(DEPTH)
ADDR_W, 32, store address width
DATA_W, 64, store data width
SIZE_W, 2, access-size code width (00=byte, 01=word, 10=dword, 11=qword)

Ports:
CLK  in  1  clock, rising edge
CLR  in  1  asynchronous reset, active-high
wr_valid  in  1  WB presents a committed store this cycle
wr_addr  in  ADDR_W  store address
wr_data  in  DATA_W  store data
wr_size  in  SIZE_W  store size code
wr_stall  out  1  buffer cannot accept; WB must hold its store and stall EX
mem_wt_en  out  1  head entry valid, write request to MEM
mem_wt_addr  out  ADDR_W  head entry address
mem_wt_data  out  DATA_W  head entry data
mem_wt_size  out  SIZE_W  head entry size
mem_busy  in  1  MEM cannot accept the write this cycle
chk_addr  in  ADDR_W  PRE-stage load address to check
chk_hit  out  1  pending or incoming store is in the same 8-byte block as chk_addr
flush_req  in  1  request drain (level)
flush_done  out  1  one-cycle pulse: drain complete
count  out  PTR_W+1  occupied entries
empty  out  1  count==0

Behaviour:
- Storage: circular FIFO; head/tail pointers PTR_W bits, wrap modulo DEPTH; count PTR_W+1 bits, 0..DEPTH.
- Reset (CLR=1, async): pointers=0, count=0, every entry valid bit and field=0, FSM=IDLE. Outputs: wr_stall=0, mem_wt_en=0, mem_wt_addr/data/size=0, chk_hit=0, flush_done=0, empty=1.
- Push: wr_valid && !wr_stall at a rising edge writes the tail entry and advances tail. The entry is visible on mem_wt_* in the next cycle at the earliest (1-cycle latency, no bypass).
- Pop: mem_wt_en = !empty. The head entry retires at the edge where mem_wt_en && !mem_busy. mem_wt_* are driven from head registers and held stable while mem_busy=1.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- wr_stall = (count==DEPTH) || FSM!=IDLE. It is decoded from registered state only, with no combinational path from mem_busy.
  - When full, a pop in the same cycle does not admit a push; the push is accepted the next cycle.
- Pushes while wr_stall=1 are ignored; contents and count are unchanged.
- chk_hit (combinational) is set when either:
  - any valid entry has addr[ADDR_W-1:3]==chk_addr[ADDR_W-1:3], or
  - wr_valid && !wr_stall && wr_addr[ADDR_W-1:3]==chk_addr[ADDR_W-1:3].
  - An entry retiring this cycle still counts as a hit.
- FSM states:
  - IDLE: flush_req=1 -> DRAIN.
  - DRAIN: stall pushes; when count==0 -> DONE.
  - DONE: flush_done=1 for exactly one cycle -> WAIT.
  - WAIT: hold stall until flush_req=0 -> IDLE.
- flush_req asserted while already empty: IDLE -> DRAIN -> DONE. flush_done rises 2 cycles after flush_req.
- flush_req deasserted during DRAIN: draining continues to DONE; WAIT then exits immediately.
- CLR mid-operation discards all pending stores and aborts any drain. flush_done is not issued.
- Entries always retire in program order. There is no write merging.

Test Plan:
- Reset, then push addr=0x1000 data=0x11 size=10 with mem_busy=0 -> mem_wt_en=1 next cycle with addr=0x1000; retires; empty=1 after 2 edges.
- mem_busy=1, push 4 stores (DEPTH=4) -> count=4, wr_stall=1; 5th push ignored; release mem_busy -> 4 writes in order, one per cycle; wr_stall drops the cycle after first retire.
- count=2, push and pop in the same cycle -> count stays 2, order preserved across pointer wrap (push 6 total at DEPTH=4).
- Pending store 0x2004, chk_addr=0x2000 -> chk_hit=1; chk_addr=0x2008 -> 0; incoming wr_addr=0x3000 with chk_addr=0x3007 same cycle -> 1.
- 3 entries, mem_busy=1 for 5 cycles, flush_req=1 -> wr_stall=1 throughout; flush_done one-cycle pulse the cycle after count reaches 0; IDLE after flush_req drops.
- Assert CLR while count=3 in DRAIN -> all outputs at reset values immediately, no flush_done, subsequent push works normally.
